// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller:
//   - stall vector constants (bit0 pc .. bit5 wb)
//   - controller state encodings
//   - default exception vector and reset polarity
//   - stall_prio(): fixed-priority stall request arbitration
package pipe_ctrl_pkg;

    // A stalled stage with an unstalled successor injects a bubble
    // downstream, so each vector is a contiguous run of ones from the PC.
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_HOLD_EXC = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0000_0020;

    localparam logic RstEnable = 1'b1;

    // Deepest stalled stage wins: mem, then ex, then id, then if.
    function automatic logic [5:0] stall_prio(
        input logic req_mem,
        input logic req_ex,
        input logic req_id,
        input logic req_if
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog
// Counts consecutive stalled cycles, saturating at TIMEOUT, and raises a
// sticky flag once the count reaches TIMEOUT. The flag clears only on rst.
// Ports:
//   clk           in  clock
//   rst           in  synchronous active-high reset
//   stall_active  in  the pipeline is stalled this cycle
//   timeout       out sticky watchdog flag (registered)
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic timeout
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_count;
    logic         r_timeout;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!stall_active) begin
                r_count <= '0;
            end else if (r_count != LIMIT) begin
                r_count <= r_count + W'(1);
            end
            // Sets on the edge where the count reaches LIMIT.
            if (stall_active && (r_count >= LIMIT - W'(1))) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout = r_timeout;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencing controller for the 5-stage core. Arbitrates stage
// stall requests into one stall vector, sequences exception/eret redirect
// as squash (stall=011111) followed by a one-cycle flush, and keeps stall
// statistics plus a consecutive-stall watchdog.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stallreq_if/id/ex/mem    per-stage stall requests
//   excp_valid, excp_is_eret MEM-stage exception / eret report
//   cp0_epc                  eret return address
//   stall[5:0]               combinational stall vector (bit0 pc .. bit5 wb)
//   flush, new_pc            registered redirect, new_pc valid while flush=1
//   stall_cycles             cycles with stall!=0 (wraps)
//   flush_count              number of flushes (wraps)
//   stall_timeout            sticky watchdog flag
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEFAULT,
    parameter int          TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_valid,
    input  logic        excp_is_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
    output logic        stall_timeout
);

    logic [1:0]  r_state;
    logic        r_flush;
    logic [31:0] r_target;
    logic [31:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    logic [1:0]  w_state_next;
    logic [5:0]  w_stall;
    logic        w_accept;
    logic [31:0] w_target;

    assign w_target = excp_is_eret ? cp0_epc : EXC_VEC;

    always_comb begin
        w_stall      = STALL_NONE;
        w_state_next = r_state;
        w_accept     = 1'b0;
        if (rst != RstEnable) begin
            case (r_state)
                ST_FLUSH: begin
                    // Redirect cycle: everything upstream is ignored.
                    w_state_next = ST_RUN;
                end
                default: begin
                    w_stall = stall_prio(stallreq_mem, stallreq_ex,
                                         stallreq_id, stallreq_if);
                    if (stallreq_mem && (excp_valid || r_state == ST_HOLD_EXC)) begin
                        // Faulting instruction is still waiting on the data
                        // bus; defer and re-sample once the bus releases.
                        w_state_next = ST_HOLD_EXC;
                    end else if (excp_valid) begin
                        // Freeze pc..ex_mem and bubble mem_wb so the
                        // faulting instruction never retires.
                        w_accept     = 1'b1;
                        w_stall      = STALL_MEM;
                        w_state_next = ST_FLUSH;
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state        <= ST_RUN;
            r_flush        <= 1'b0;
            r_target       <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_state_next;
            r_flush <= w_accept;
            if (w_accept) begin
                r_target <= w_target;
            end
            if (r_state == ST_FLUSH) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
            if (w_stall != STALL_NONE) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    stall_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (w_stall != STALL_NONE),
        .timeout      (stall_timeout)
    );

    assign stall        = w_stall;
    assign flush        = r_flush;
    assign new_pc       = r_target;
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural model.
module tb_pipe_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0, stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        excp_valid = 1'b0, excp_is_eret = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
    logic        stall_timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: redirect pending, deferred exception, counters.
    bit          m_flushing = 0;
    bit          m_deferred = 0;
    bit          m_just_reset = 0;
    logic [31:0] m_target = '0;
    logic [31:0] m_stall_cycles = '0;
    logic [15:0] m_flush_count = '0;
    int          m_consec = 0;
    bit          m_timeout = 0;

    pipe_ctrl #(
        .EXC_VEC (32'h0000_0020),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_valid    (excp_valid),
        .excp_is_eret  (excp_is_eret),
        .cp0_epc       (cp0_epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_cycles  (stall_cycles),
        .flush_count   (flush_count),
        .stall_timeout (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Number of stalled registers counted from the PC: the vector is that
    // many ones in the low bits.
    function automatic logic [5:0] model_stall();
        int n;
        if (rst || m_flushing) return 6'b0;
        if (stallreq_mem)      n = 5;
        else if (stallreq_ex)  n = 4;
        else if (stallreq_id)  n = 3;
        else if (stallreq_if)  n = 2;
        else                   n = 0;
        if (excp_valid && !stallreq_mem) n = 5;
        return 6'((1 << n) - 1);
    endfunction

    // One clock: check stall mid-cycle, advance model, check registered outputs.
    task automatic cycle();
        logic [5:0] es;
        @(negedge clk);
        es = model_stall();
        chk("stall", 32'(stall), 32'(es));
        if (rst) begin
            m_flushing = 0; m_deferred = 0; m_target = '0;
            m_stall_cycles = '0; m_flush_count = '0; m_consec = 0;
            m_timeout = 0; m_just_reset = 1;
        end else begin
            m_just_reset = 0;
            if (es != 0) begin
                m_stall_cycles = m_stall_cycles + 1;
                m_consec = (m_consec < TMO) ? m_consec + 1 : TMO;
            end else begin
                m_consec = 0;
            end
            if (m_consec >= TMO) m_timeout = 1;
            if (m_flushing) begin
                m_flush_count = m_flush_count + 1;
                m_flushing = 0;
                m_deferred = 0;
            end else if (excp_valid && !stallreq_mem) begin
                m_target = excp_is_eret ? cp0_epc : 32'h0000_0020;
                m_flushing = 1;
                m_deferred = 0;
            end else begin
                m_deferred = stallreq_mem && (excp_valid || m_deferred);
            end
        end
        @(posedge clk);
        #1;
        chk("flush", 32'(flush), 32'(m_flushing));
        if (m_flushing || m_just_reset) chk("new_pc", new_pc, m_target);
        chk("stall_cycles", stall_cycles, m_stall_cycles);
        chk("flush_count", 32'(flush_count), 32'(m_flush_count));
        chk("stall_timeout", 32'(stall_timeout), 32'(m_timeout));
    endtask

    task automatic set_req(input logic mem, input logic ex, input logic id, input logic ifs);
        stallreq_mem = mem; stallreq_ex = ex; stallreq_id = id; stallreq_if = ifs;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        chk("rst_flush_count", 32'(flush_count), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);

        // Priority
        set_req(0, 0, 1, 1); #1;
        chk("prio_id_if", 32'(stall), 32'b000111);
        cycle();
        set_req(1, 0, 1, 1); #1;
        chk("prio_mem", 32'(stall), 32'b011111);
        cycle();
        set_req(0, 0, 0, 0); #1;
        chk("prio_none", 32'(stall), 32'b000000);
        cycle();

        // Exception without mem stall
        excp_valid = 1; excp_is_eret = 0; #1;
        chk("exc_squash", 32'(stall), 32'b011111);
        cycle();
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_new_pc", new_pc, 32'h0000_0020);
        excp_valid = 0;
        cycle();
        chk("exc_flush_done", 32'(flush), 32'h0);
        chk("exc_flush_count", 32'(flush_count), 32'h1);

        // Deferred eret
        excp_valid = 1; excp_is_eret = 1; cp0_epc = 32'h0000_1234;
        set_req(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("eret_hold_stall", 32'(stall), 32'b011111);
            cycle();
            chk("eret_hold_noflush", 32'(flush), 32'h0);
        end
        set_req(0, 0, 0, 0); #1;
        chk("eret_accept_stall", 32'(stall), 32'b011111);
        cycle();
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_new_pc", new_pc, 32'h0000_1234);
        excp_valid = 0; excp_is_eret = 0;
        cycle();

        // Watchdog from a clean reset
        rst = 1; cycle(); rst = 0;
        set_req(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("wd_before", 32'(stall_timeout), 32'h0);
        cycle();
        chk("wd_trip", 32'(stall_timeout), 32'h1);
        chk("wd_stall_cycles", stall_cycles, 32'd4);
        set_req(0, 0, 0, 0);
        cycle();
        chk("wd_sticky", 32'(stall_timeout), 32'h1);

        // Reset during flush
        excp_valid = 1; excp_is_eret = 0;
        cycle();
        chk("mid_flush", 32'(flush), 32'h1);
        rst = 1; excp_valid = 0;
        cycle();
        rst = 0; #1;
        chk("rstf_flush", 32'(flush), 32'h0);
        chk("rstf_stall", 32'(stall), 32'h0);
        chk("rstf_stall_cycles", stall_cycles, 32'h0);
        chk("rstf_flush_count", 32'(flush_count), 32'h0);
        chk("rstf_timeout", 32'(stall_timeout), 32'h0);
        excp_valid = 1;
        #1;
        chk("rstf_run_accept", 32'(stall), 32'b011111);
        cycle();
        chk("rstf_run_flush", 32'(flush), 32'h1);
        excp_valid = 0;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            stallreq_mem = ($urandom_range(0, 3) == 0);
            stallreq_ex  = ($urandom_range(0, 5) == 0);
            stallreq_id  = ($urandom_range(0, 5) == 0);
            stallreq_if  = ($urandom_range(0, 4) == 0);
            excp_valid   = ($urandom_range(0, 4) == 0);
            excp_is_eret = $urandom_range(0, 1) == 1;
            cp0_epc      = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
